// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
//   Sequences the program counter and the instruction-memory fetch in the IF stage.
//   Every cycle it chooses the next PC: sequential, branch redirect or hold.
//   It also runs the fetch handshake with instruction memory.
//   It tells IF/ID whether this cycle's word is valid or must be squashed.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (0 = in reset)
//   pc_current     present value of the external PC register
//   pc_next        value to load into the PC register
//   pc_write       PC register load enable
//   imem_req       fetch request to instruction memory
//   imem_addr      fetch address
//   imem_ready     instruction word valid / request accepted this cycle
//   stall          hazard unit: hold PC, do not deliver the fetched word
//   branch_taken   EX stage redirect pulse
//   branch_target  redirect address
//   if_valid       fetched word goes into IF/ID this cycle
//   if_flush       squash IF/ID contents this cycle
//   state_o        debug view of the FSM: BOOT=0, FETCH=1, WAIT=2
//
// Handshake: a fetch is in progress whenever imem_req=1. It completes in the
// cycle that imem_ready=1. Until then imem_addr is held constant. The request
// is never withdrawn except by reset, and memory must tolerate that abandoned
// request.
module pc_fetch_controller #(
  parameter int              XLEN         = 64,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BOOT_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_write,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            if_valid,
  output logic            if_flush,
  output logic [1:0]      state_o
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam int              CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [XLEN-1:0]  STEP      = XLEN'(INSTR_BYTES);

  logic [1:0]      state, state_nxt;
  logic [CNT_W-1:0] boot_cnt, boot_cnt_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [XLEN-1:0] pend_target, pend_target_nxt;
  logic [XLEN-1:0] req_addr, req_addr_nxt;

  assign state_o = state;

  always_comb begin
    state_nxt       = state;
    boot_cnt_nxt    = boot_cnt;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    req_addr_nxt    = req_addr;
    pc_next         = RESET_VECTOR;
    pc_write        = 1'b0;
    imem_req        = 1'b0;
    imem_addr       = '0;
    if_valid        = 1'b0;
    if_flush        = 1'b0;

    // While reset is low, the state is already BOOT. The gate also masks
    // the boot pulse in that case, because with BOOT_CYCLES=1 the boot
    // pulse would otherwise be active during reset.
    if (reset) begin
      case (state)
        ST_BOOT: begin
          boot_cnt_nxt = boot_cnt + CNT_W'(1);
          if (boot_cnt == BOOT_LAST) begin
            pc_write  = 1'b1;
            pc_next   = RESET_VECTOR;
            state_nxt = ST_FETCH;
          end
        end

        ST_FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_current;
          if (imem_ready) begin
            if (branch_taken) begin
              pc_next  = branch_target;
              pc_write = 1'b1;
              if_flush = 1'b1;
            end else if (!stall) begin
              pc_next  = pc_current + STEP;
              pc_write = 1'b1;
              if_valid = 1'b1;
            end
            // Stall: the PC is held, so the same address is refetched.
          end else begin
            req_addr_nxt = pc_current;
            state_nxt    = ST_WAIT;
            if (branch_taken) begin
              pend_valid_nxt  = 1'b1;
              pend_target_nxt = branch_target;
            end
          end
        end

        ST_WAIT: begin
          imem_req  = 1'b1;
          imem_addr = req_addr;
          if (!imem_ready) begin
            // If several redirects arrive during one wait, the latest one is used.
            if (branch_taken) begin
              pend_valid_nxt  = 1'b1;
              pend_target_nxt = branch_target;
            end
          end else begin
            state_nxt      = ST_FETCH;
            pend_valid_nxt = 1'b0;
            if (branch_taken || pend_valid) begin
              pc_next  = branch_taken ? branch_target : pend_target;
              pc_write = 1'b1;
              if_flush = 1'b1;
            end else if (!stall) begin
              pc_next  = req_addr + STEP;
              pc_write = 1'b1;
              if_valid = 1'b1;
            end
          end
        end

        default: state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_BOOT;
      boot_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      req_addr    <= '0;
    end else begin
      state       <= state_nxt;
      boot_cnt    <= boot_cnt_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      req_addr    <= req_addr_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller
//   Testbench for pc_fetch_controller. It runs directed scenarios and then
//   randomized traffic. A transaction-level reference model produces the
//   expected outputs: it tracks the boot countdown, the outstanding fetch
//   and a queue of pending redirect targets. The bench owns the PC register
//   and loads it from the DUT's pc_next/pc_write.
module tb_pc_fetch_controller;

  localparam int          XLEN = 64;
  localparam int          IB   = 4;
  localparam logic [63:0] RV   = 64'h0;
  localparam int          BC   = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [XLEN-1:0] pc_current;
  logic [XLEN-1:0] pc_next;
  logic            pc_write;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            if_valid;
  logic            if_flush;
  logic [1:0]      state_o;

  pc_fetch_controller #(
    .XLEN(XLEN), .INSTR_BYTES(IB), .RESET_VECTOR(RV), .BOOT_CYCLES(BC)
  ) dut (
    .clk(clk), .reset(reset), .pc_current(pc_current), .pc_next(pc_next),
    .pc_write(pc_write), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .if_valid(if_valid), .if_flush(if_flush),
    .state_o(state_o)
  );

  int checks   = 0;
  int failures = 0;

  // Bench-owned PC register
  logic [63:0] pc_reg;

  // Reference model state
  bit          m_booted;
  int          m_elapsed;
  bit          m_inflight;
  logic [63:0] m_addr;
  logic [63:0] m_redir[$];

  // Expected outputs for the current cycle
  logic        e_write, e_req, e_valid, e_flush;
  logic [63:0] e_next, e_addr;
  logic [1:0]  e_state;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_eval(input bit rst, input bit rdy, input bit stl,
                            input bit br, input logic [63:0] tgt);
    e_write = 1'b0; e_next = RV; e_req = 1'b0; e_addr = '0;
    e_valid = 1'b0; e_flush = 1'b0; e_state = 2'd0;
    if (rst) begin
      if (!m_booted) begin
        if (m_elapsed == BC - 1) begin
          e_write = 1'b1;
          e_next  = RV;
        end
      end else begin
        e_req   = 1'b1;
        e_addr  = m_inflight ? m_addr : pc_reg;
        e_state = m_inflight ? 2'd2 : 2'd1;
        if (rdy) begin
          if (br || m_redir.size() > 0) begin
            e_flush = 1'b1;
            e_write = 1'b1;
            e_next  = br ? tgt : m_redir[$];
          end else if (!stl) begin
            e_write = 1'b1;
            e_valid = 1'b1;
            e_next  = e_addr + 64'(IB);
          end
        end
      end
    end
  endtask

  task automatic model_update(input bit rst, input bit rdy, input bit br,
                              input logic [63:0] tgt, input logic [63:0] pc_seen);
    if (!rst) begin
      m_booted = 0; m_elapsed = 0; m_inflight = 0; m_redir.delete();
    end else if (!m_booted) begin
      if (m_elapsed == BC - 1) m_booted = 1;
      else m_elapsed++;
    end else if (rdy) begin
      m_inflight = 0;
      m_redir.delete();
    end else begin
      if (!m_inflight) begin
        m_inflight = 1;
        m_addr     = pc_seen;
      end
      if (br) m_redir.push_back(tgt);
    end
  endtask

  // Driver: this task runs one clock cycle.
  task automatic step(input bit rst, input bit rdy, input bit stl,
                      input bit br, input logic [63:0] tgt);
    logic        cap_w;
    logic [63:0] cap_n;
    logic [63:0] pc_seen;
    @(negedge clk);
    reset = rst; imem_ready = rdy; stall = stl;
    branch_taken = br; branch_target = tgt; pc_current = pc_reg;
    pc_seen = pc_reg;
    #1;
    model_eval(rst, rdy, stl, br, tgt);
    check("state_o",  64'(state_o),  64'(e_state));
    check("pc_write", 64'(pc_write), 64'(e_write));
    check("imem_req", 64'(imem_req), 64'(e_req));
    check("if_valid", 64'(if_valid), 64'(e_valid));
    check("if_flush", 64'(if_flush), 64'(e_flush));
    if (e_req || !rst)   check("imem_addr", imem_addr, e_addr);
    if (e_write || !rst) check("pc_next",   pc_next,   e_next);
    check("valid_and_flush", 64'(if_valid & if_flush), 64'd0);
    cap_w = pc_write;
    cap_n = pc_next;
    @(posedge clk);
    model_update(rst, rdy, br, tgt, pc_seen);
    if (rst && cap_w) pc_reg = cap_n;
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; pc_current = '0;
    pc_reg = 64'hDEAD_0000;
    m_booted = 0; m_elapsed = 0; m_inflight = 0; m_addr = '0;

    // Reset held
    repeat (3) step(0, 1, 0, 0, 64'h0);

    // Boot then fetch sequentially at 0, 4, 8, ...
    repeat (8) step(1, 1, 0, 0, 64'h0);
    check("boot_seq_pc", pc_reg, 64'd24);

    // Three stall cycles, then resume
    pc_reg = 64'h100;
    repeat (3) step(1, 1, 1, 0, 64'h0);
    check("stall_hold_pc", pc_reg, 64'h100);
    step(1, 1, 0, 0, 64'h0);
    check("stall_resume_pc", pc_reg, 64'h104);

    // Branch taken while in FETCH
    pc_reg = 64'h40;
    step(1, 1, 0, 1, 64'h200);
    check("fetch_branch_pc", pc_reg, 64'h200);

    // Four wait cycles with two redirects; the later one wins
    pc_reg = 64'h80;
    step(1, 0, 0, 0, 64'h0);
    step(1, 0, 0, 1, 64'h300);
    step(1, 0, 0, 0, 64'h0);
    step(1, 0, 0, 1, 64'h400);
    step(1, 1, 0, 0, 64'h0);
    check("wait_redirect_pc", pc_reg, 64'h400);

    // Increment wraps modulo 2^64
    pc_reg = 64'hFFFF_FFFF_FFFF_FFFC;
    step(1, 1, 0, 0, 64'h0);
    check("wrap_pc", pc_reg, 64'h0);

    // Reset while a wait with a pending redirect is in progress
    pc_reg = 64'h500;
    step(1, 0, 0, 1, 64'h600);
    step(0, 0, 0, 0, 64'h0);
    step(0, 1, 0, 0, 64'h0);
    repeat (4) step(1, 1, 0, 0, 64'h0);
    check("reset_restart_pc", pc_reg, 64'd8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit          r_rst, r_rdy, r_stl, r_br;
      logic [63:0] r_tgt;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_rdy = ($urandom_range(0, 99) < 65);
      r_stl = ($urandom_range(0, 99) < 20);
      r_br  = ($urandom_range(0, 99) < 15);
      r_tgt = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 19) == 0) pc_reg = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
      step(r_rst, r_rdy, r_stl, r_br, r_tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
